// File: rtl/muldiv_sequencer.sv
// ----------------------------------------------------------------------------
// muldiv_sequencer
//
// Sits between the multicycle control unit and the shared multiply / divide
// units. Accepts one HI/LO operation at a time (MULT, DIV, MTHI, MTLO), starts
// the matching unit with a level-type start signal, and holds that level until
// the unit reports completion. On completion it commits the result into the
// architectural HI/LO registers. It then drops the start level for one DRAIN
// cycle so the unit can rearm. Divide-by-zero is caught before the divider is
// started. A run that never completes is aborted after TIMEOUT_CYCLES.
//
// Parameters
//   TIMEOUT_CYCLES : cycles allowed in a RUN state before the op is aborted (>=2)
//
// Ports
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   op_valid, op        : request strobe (sampled only when idle) and opcode
//                         (00 MULT, 01 DIV, 10 MTHI, 11 MTLO)
//   rs_val, rt_val      : operand A / operand B
//   mult_a/b, mult_ctrl : latched operands and start level to the multiplier
//   mult_stop/hi/lo     : multiplier completion and result words
//   div_a/b, div_ctrl   : latched operands and start level to the divider
//   div_done/zero/hi/lo : divider completion, zero flag, remainder, quotient
//   hi, lo              : architectural HI / LO
//   busy                : combinational, high whenever the sequencer is not idle
//   done                : one-cycle pulse, op committed
//   div0_exc            : one-cycle pulse, divide by zero (HI/LO unchanged)
//   err_timeout         : one-cycle pulse, unit never completed (HI/LO unchanged)
// ----------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] mult_a,
    output logic [31:0] mult_b,
    output logic        mult_ctrl,
    input  logic        mult_stop,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_ctrl,
    input  logic        div_done,
    input  logic        div_zero,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div0_exc,
    output logic        err_timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULT_RUN = 2'd1,
        DIV_RUN  = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    state_t           r_state,     w_state_nxt;
    logic [CNT_W-1:0] r_count,     w_count_nxt;
    logic [31:0]      r_mult_a,    w_mult_a_nxt;
    logic [31:0]      r_mult_b,    w_mult_b_nxt;
    logic [31:0]      r_div_a,     w_div_a_nxt;
    logic [31:0]      r_div_b,     w_div_b_nxt;
    logic             r_mult_ctrl, w_mult_ctrl_nxt;
    logic             r_div_ctrl,  w_div_ctrl_nxt;
    logic [31:0]      r_hi,        w_hi_nxt;
    logic [31:0]      r_lo,        w_lo_nxt;
    logic             r_done,      w_done_nxt;
    logic             r_div0,      w_div0_nxt;
    logic             r_tmo,       w_tmo_nxt;

    // State and all registered outputs; reset drops the start levels at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_mult_a    <= '0;
            r_mult_b    <= '0;
            r_div_a     <= '0;
            r_div_b     <= '0;
            r_mult_ctrl <= 1'b0;
            r_div_ctrl  <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_done      <= 1'b0;
            r_div0      <= 1'b0;
            r_tmo       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_mult_a    <= w_mult_a_nxt;
            r_mult_b    <= w_mult_b_nxt;
            r_div_a     <= w_div_a_nxt;
            r_div_b     <= w_div_b_nxt;
            r_mult_ctrl <= w_mult_ctrl_nxt;
            r_div_ctrl  <= w_div_ctrl_nxt;
            r_hi        <= w_hi_nxt;
            r_lo        <= w_lo_nxt;
            r_done      <= w_done_nxt;
            r_div0      <= w_div0_nxt;
            r_tmo       <= w_tmo_nxt;
        end
    end

    // Next-state and next-output logic. Status pulses default low so each
    // one lasts exactly one cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_mult_a_nxt    = r_mult_a;
        w_mult_b_nxt    = r_mult_b;
        w_div_a_nxt     = r_div_a;
        w_div_b_nxt     = r_div_b;
        w_mult_ctrl_nxt = r_mult_ctrl;
        w_div_ctrl_nxt  = r_div_ctrl;
        w_hi_nxt        = r_hi;
        w_lo_nxt        = r_lo;
        w_done_nxt      = 1'b0;
        w_div0_nxt      = 1'b0;
        w_tmo_nxt       = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (op_valid) begin
                    unique case (op)
                        OP_MULT: begin
                            w_mult_a_nxt    = rs_val;
                            w_mult_b_nxt    = rt_val;
                            w_mult_ctrl_nxt = 1'b1;
                            w_count_nxt     = '0;
                            w_state_nxt     = MULT_RUN;
                        end
                        OP_DIV: begin
                            // Zero divisor never reaches the divider.
                            if (rt_val == 32'd0) begin
                                w_div0_nxt = 1'b1;
                            end else begin
                                w_div_a_nxt    = rs_val;
                                w_div_b_nxt    = rt_val;
                                w_div_ctrl_nxt = 1'b1;
                                w_count_nxt    = '0;
                                w_state_nxt    = DIV_RUN;
                            end
                        end
                        OP_MTHI: begin
                            w_hi_nxt   = rs_val;
                            w_done_nxt = 1'b1;
                        end
                        OP_MTLO: begin
                            w_lo_nxt   = rs_val;
                            w_done_nxt = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            MULT_RUN: begin
                w_count_nxt = r_count + CNT_W'(1);
                // Completion is checked first so it wins over a same-edge timeout.
                if (mult_stop) begin
                    w_hi_nxt        = mult_hi;
                    w_lo_nxt        = mult_lo;
                    w_done_nxt      = 1'b1;
                    w_mult_ctrl_nxt = 1'b0;
                    w_state_nxt     = DRAIN;
                end else if (r_count == CNT_LAST) begin
                    w_mult_ctrl_nxt = 1'b0;
                    w_tmo_nxt       = 1'b1;
                    w_state_nxt     = DRAIN;
                end
            end

            DIV_RUN: begin
                w_count_nxt = r_count + CNT_W'(1);
                if (div_done) begin
                    if (div_zero) begin
                        w_div0_nxt = 1'b1;
                    end else begin
                        w_hi_nxt   = div_hi;
                        w_lo_nxt   = div_lo;
                        w_done_nxt = 1'b1;
                    end
                    w_div_ctrl_nxt = 1'b0;
                    w_state_nxt    = DRAIN;
                end else if (r_count == CNT_LAST) begin
                    w_div_ctrl_nxt = 1'b0;
                    w_tmo_nxt      = 1'b1;
                    w_state_nxt    = DRAIN;
                end
            end

            DRAIN: begin
                // One cycle with both start levels low so the unit rearms.
                w_mult_ctrl_nxt = 1'b0;
                w_div_ctrl_nxt  = 1'b0;
                w_state_nxt     = IDLE;
            end

            default: w_state_nxt = IDLE;
        endcase
    end

    assign mult_a      = r_mult_a;
    assign mult_b      = r_mult_b;
    assign mult_ctrl   = r_mult_ctrl;
    assign div_a       = r_div_a;
    assign div_b       = r_div_b;
    assign div_ctrl    = r_div_ctrl;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign done        = r_done;
    assign div0_exc    = r_div0;
    assign err_timeout = r_tmo;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val;
    logic [31:0] mult_a, mult_b, mult_hi, mult_lo;
    logic        mult_ctrl, mult_stop;
    logic [31:0] div_a, div_b, div_hi, div_lo;
    logic        div_ctrl, div_done, div_zero;
    logic [31:0] hi, lo;
    logic        busy, done, div0_exc, err_timeout;

    int total = 0;
    int bad   = 0;

    // Unit stub configuration
    int   m_lat = 3, d_lat = 3;
    bit   m_en = 1'b1, d_en = 1'b1, d_zero_cfg = 1'b0;
    logic x_div_done = 1'b0;
    int   m_cnt = 0, d_cnt = 0;
    logic m_stop_s = 1'b0, d_done_s = 1'b0;

    // Reference model of the architectural registers
    logic [31:0] m_hi = '0, m_lo = '0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .rs_val(rs_val), .rt_val(rt_val),
        .mult_a(mult_a), .mult_b(mult_b), .mult_ctrl(mult_ctrl),
        .mult_stop(mult_stop), .mult_hi(mult_hi), .mult_lo(mult_lo),
        .div_a(div_a), .div_b(div_b), .div_ctrl(div_ctrl),
        .div_done(div_done), .div_zero(div_zero), .div_hi(div_hi), .div_lo(div_lo),
        .hi(hi), .lo(lo), .busy(busy), .done(done),
        .div0_exc(div0_exc), .err_timeout(err_timeout)
    );

    // Behavioural mult/div units: signed arithmetic, completion after a
    // configurable latency while the start level is held.
    logic signed [63:0] w_prod;
    logic signed [31:0] w_q, w_r;
    assign w_prod  = $signed(mult_a) * $signed(mult_b);
    assign mult_hi = w_prod[63:32];
    assign mult_lo = w_prod[31:0];
    assign w_q     = (div_b == 32'd0) ? 32'sd0 : $signed(div_a) / $signed(div_b);
    assign w_r     = (div_b == 32'd0) ? 32'sd0 : $signed(div_a) % $signed(div_b);
    assign div_lo  = w_q;
    assign div_hi  = w_r;
    assign mult_stop = m_stop_s;
    assign div_done  = d_done_s | x_div_done;
    assign div_zero  = d_zero_cfg;

    always @(posedge clk) begin
        if (mult_ctrl) begin
            m_cnt    <= m_cnt + 1;
            m_stop_s <= m_en && (m_cnt >= m_lat - 1);
        end else begin
            m_cnt    <= 0;
            m_stop_s <= 1'b0;
        end
        if (div_ctrl) begin
            d_cnt    <= d_cnt + 1;
            d_done_s <= d_en && (d_cnt >= d_lat - 1);
        end else begin
            d_cnt    <= 0;
            d_done_s <= 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op while idle, predict its outcome from the operation rules,
    // and check flags, HI/LO and the DRAIN/busy sequencing.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        logic [31:0] eh, el;
        logic [2:0]  eflags;
        int          kind;
        bit          seen;
        eh = m_hi; el = m_lo; kind = 0;
        case (o)
            2'd0: if (m_en) begin
                      p = $signed(a) * $signed(b);
                      eh = p[63:32]; el = p[31:0];
                  end else kind = 2;
            2'd1: if (b == 32'd0) kind = 1;
                  else if (!d_en) kind = 2;
                  else if (d_zero_cfg) kind = 1;
                  else begin
                      el = $signed(a) / $signed(b);
                      eh = $signed(a) % $signed(b);
                  end
            2'd2: eh = a;
            default: el = a;
        endcase
        eflags = (kind == 0) ? 3'b100 : (kind == 1) ? 3'b010 : 3'b001;

        op_valid = 1'b1; op = o; rs_val = a; rt_val = b;
        step();
        op_valid = 1'b0; rs_val = $urandom; rt_val = $urandom;

        if (o >= 2'd2 || (o == 2'd1 && b == 32'd0)) begin
            chk({tag, "_flags"}, 64'({done, div0_exc, err_timeout}), 64'(eflags));
            chk({tag, "_busy"}, 64'(busy), 64'(0));
            chk({tag, "_ctrl"}, 64'({mult_ctrl, div_ctrl}), 64'(0));
            chk({tag, "_hi"}, 64'(hi), 64'(eh));
            chk({tag, "_lo"}, 64'(lo), 64'(el));
        end else begin
            chk({tag, "_busy_run"}, 64'(busy), 64'(1));
            if (o == 2'd0) begin
                chk({tag, "_mctrl"}, 64'({mult_ctrl, div_ctrl}), 64'(2'b10));
                chk({tag, "_mops"}, {mult_a, mult_b}, {a, b});
            end else begin
                chk({tag, "_dctrl"}, 64'({mult_ctrl, div_ctrl}), 64'(2'b01));
                chk({tag, "_dops"}, {div_a, div_b}, {a, b});
            end
            seen = 1'b0;
            for (int k = 0; k < 200 && !seen; k++) begin
                step();
                seen = done | div0_exc | err_timeout;
            end
            chk({tag, "_finished"}, 64'(seen), 64'(1));
            chk({tag, "_flags"}, 64'({done, div0_exc, err_timeout}), 64'(eflags));
            chk({tag, "_hi"}, 64'(hi), 64'(eh));
            chk({tag, "_lo"}, 64'(lo), 64'(el));
            chk({tag, "_drain_busy"}, 64'(busy), 64'(1));
            chk({tag, "_drain_ctrl"}, 64'({mult_ctrl, div_ctrl}), 64'(0));
            step();
            chk({tag, "_idle_busy"}, 64'(busy), 64'(0));
            chk({tag, "_pulse_end"}, 64'({done, div0_exc, err_timeout}), 64'(0));
        end
        m_hi = eh; m_lo = el;
    endtask

    initial begin
        int          k;
        bit          seen;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int          sel;

        reset = 1'b1; op_valid = 1'b0; op = '0; rs_val = '0; rt_val = '0;
        step(); step();
        chk("reset_outputs", 64'(|{mult_a, mult_b, mult_ctrl, div_a, div_b, div_ctrl,
                                   hi, lo, busy, done, div0_exc, err_timeout}), 64'(0));
        reset = 1'b0;
        step();

        // Directed cases
        run_op("mult_6x7", 2'd0, 32'd6, 32'd7);
        chk("mult_6x7_val", {hi, lo}, 64'd42);
        run_op("mult_neg", 2'd0, 32'hFFFF_FFFB, 32'd3);
        chk("mult_neg_val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("div_23_7", 2'd1, 32'd23, 32'd7);
        chk("div_23_7_val", {hi, lo}, {32'd2, 32'd3});
        run_op("div_by0", 2'd1, 32'd10, 32'd0);
        chk("div_by0_keep", {hi, lo}, {32'd2, 32'd3});
        run_op("mtlo", 2'd3, 32'h0BAD_F00D, 32'd0);

        // Divider reports divide-by-zero at completion
        d_zero_cfg = 1'b1;
        run_op("div_zflag", 2'd1, 32'd100, 32'd9);
        d_zero_cfg = 1'b0;

        // Completion input of the idle unit is ignored during MULT_RUN
        m_lat = 6;
        op_valid = 1'b1; op = 2'd0; rs_val = 32'd11; rt_val = 32'd13;
        step();
        op_valid = 1'b0;
        x_div_done = 1'b1; step(); step(); x_div_done = 1'b0;
        seen = 1'b0;
        for (int j = 0; j < 100 && !seen; j++) begin
            step();
            seen = done | div0_exc | err_timeout;
        end
        chk("foreign_done_seen", 64'(seen), 64'(1));
        chk("foreign_done_flag", 64'({done, div0_exc, err_timeout}), 64'(3'b100));
        chk("foreign_done_val", {hi, lo}, 64'd143);
        m_hi = 32'd0; m_lo = 32'd143;
        step();
        m_lat = 3;

        // Completion and timeout on the same edge: completion wins
        m_lat = TO - 1;
        run_op("mult_race", 2'd0, 32'd1000, 32'd1000);
        m_lat = 3;

        // Unit never completes: timeout after TO cycles, new requests ignored
        m_en = 1'b0;
        op_valid = 1'b1; op = 2'd0; rs_val = 32'd5; rt_val = 32'd5;
        step();
        op_valid = 1'b0;
        k = 0; seen = 1'b0;
        while (!seen && k < 100) begin
            if (k >= 10 && k <= 12) begin
                op_valid = 1'b1; op = 2'd2; rs_val = 32'h1234_5678;
            end else begin
                op_valid = 1'b0;
            end
            step();
            k++;
            seen = err_timeout;
        end
        op_valid = 1'b0;
        chk("tmo_seen", 64'(seen), 64'(1));
        chk("tmo_latency", 64'(k), 64'(TO));
        chk("tmo_no_done", 64'({done, div0_exc}), 64'(0));
        chk("tmo_keep", {hi, lo}, {m_hi, m_lo});
        step();
        chk("tmo_idle", 64'({busy, err_timeout}), 64'(0));
        chk("tmo_ignored_mthi", 64'(hi), 64'(m_hi));
        m_en = 1'b1;
        d_en = 1'b0;
        run_op("div_tmo", 2'd1, 32'd77, 32'd7);
        d_en = 1'b1;

        // Randomized operations
        for (int n = 0; n < 40; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            sel = $urandom_range(0, 7);
            rb = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 20)) : $urandom;
            if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
            m_lat = $urandom_range(1, 6);
            d_lat = $urandom_range(1, 6);
            d_zero_cfg = ($urandom_range(0, 9) == 0);
            run_op("rand", ro, ra, rb);
        end
        d_zero_cfg = 1'b0;

        // MTHI, then reset in the middle of a DIV run
        run_op("mthi", 2'd2, 32'hDEAD_BEEF, 32'd0);
        chk("mthi_val", 64'(hi), 64'hDEAD_BEEF);
        d_en = 1'b0;
        op_valid = 1'b1; op = 2'd1; rs_val = 32'd9; rt_val = 32'd3;
        step();
        op_valid = 1'b0;
        step(); step(); step();
        chk("pre_reset_run", 64'({busy, div_ctrl}), 64'(2'b11));
        #2 reset = 1'b1;
        #1;
        chk("async_reset_outputs", 64'(|{mult_a, mult_b, mult_ctrl, div_a, div_b, div_ctrl,
                                         hi, lo, busy, done, div0_exc, err_timeout}), 64'(0));
        step();
        chk("held_reset_outputs", 64'(|{mult_a, mult_b, mult_ctrl, div_a, div_b, div_ctrl,
                                        hi, lo, busy, done, div0_exc, err_timeout}), 64'(0));
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        d_en = 1'b1;
        step();
        run_op("mult_2p32", 2'd0, 32'd65536, 32'd65536);
        chk("mult_2p32_val", {hi, lo}, {32'd1, 32'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
